// File: rtl/key_code_gen.sv
// key_code_gen: turns two raw active-low push-keys into a 3-bit code
// {in1,in2,in3} for the downstream one-hot decoder. A debounced step key
// advances the code in MANUAL mode. A debounced mode key toggles into AUTO,
// where the code advances once every AUTO_MAX+1 clocks.
module key_code_gen #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [24:0] AUTO_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_step,
    input  logic key_mode,
    output logic in1,
    output logic in2,
    output logic in3,
    output logic auto_flag,
    output logic code_valid
);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // Index 0 is the step key, index 1 is the mode key.
    logic [1:0] key_raw;
    logic [1:0] press_flag;
    logic       step_flag;
    logic       mode_flag;

    assign key_raw   = {key_mode, key_step};
    assign step_flag = press_flag[0];
    assign mode_flag = press_flag[1];

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_key
            logic        sync1_q;
            logic        sync2_q;
            logic [19:0] cnt_q;
            logic [19:0] cnt_d;
            logic        flag_q;

            // Two-flop synchronizer; flops rest at 1 so a released key reads high.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= key_raw[k];
                    sync2_q <= sync1_q;
                end
            end

            // Low-time counter: clears on release, saturates so a long hold
            // never reaches the trigger value a second time.
            always_comb begin
                cnt_d = cnt_q;
                if (sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            // Counter state and the registered one-cycle press pulse.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    cnt_q  <= '0;
                    flag_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    flag_q <= !sync2_q && (cnt_q == CNT_MAX - 20'd1);
                end
            end

            assign press_flag[k] = flag_q;
        end
    endgenerate

    state_t      state_q;
    logic [2:0]  code_q;
    logic [24:0] auto_cnt_q;
    logic        auto_flag_q;
    logic        code_valid_q;

    // Mode/step FSM with registered outputs; mode_flag always takes priority.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= MANUAL;
            code_q       <= 3'b000;
            auto_cnt_q   <= '0;
            auto_flag_q  <= 1'b0;
            code_valid_q <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            case (state_q)
                MANUAL: begin
                    if (mode_flag) begin
                        state_q     <= AUTO;
                        auto_flag_q <= 1'b1;
                        auto_cnt_q  <= '0;
                    end else if (step_flag) begin
                        code_q       <= code_q + 3'd1;
                        code_valid_q <= 1'b1;
                    end
                end
                AUTO: begin
                    if (mode_flag) begin
                        state_q     <= MANUAL;
                        auto_flag_q <= 1'b0;
                    end else if (auto_cnt_q == AUTO_MAX) begin
                        auto_cnt_q   <= '0;
                        code_q       <= code_q + 3'd1;
                        code_valid_q <= 1'b1;
                    end else begin
                        auto_cnt_q <= auto_cnt_q + 25'd1;
                    end
                end
                default: begin
                    state_q     <= MANUAL;
                    auto_flag_q <= 1'b0;
                end
            endcase
        end
    end

    assign in1        = code_q[2];
    assign in2        = code_q[1];
    assign in3        = code_q[0];
    assign auto_flag  = auto_flag_q;
    assign code_valid = code_valid_q;

endmodule
